divider_signed: RTL and testbench

- Parametrised iterative restoring divider; next generation of the team's unsigned N-bit divider.
- Adds signed (two's-complement, truncating) mode, a busy flag, signed-overflow detection and a deterministic divide-by-zero result.
- Sits beside the ALU as a multi-cycle functional unit with a start/finished handshake.

---
 rtl/divider_signed.sv | 172 +++++++++++++++++
 tb/tb_divider_signed.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_signed.sv
// Iterative restoring divider, N bits, unsigned or two's-complement (truncating).
// One quotient bit per clock, MSB first, with a start/finished handshake and
// deterministic results for divide-by-zero and signed MIN / -1.
module divider_signed #(
  parameter int unsigned N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_undefined,
  output logic         o_overflow
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          undef_q, undef_d;
  logic          ovf_q, ovf_d;
  logic          busy_d, finished_d, undefined_d, overflow_d;
  logic [N-1:0]  quotient_d, remainder_d;

  logic          dvd_neg, dsr_neg;
  logic [N-1:0]  dvd_mag, dsr_mag;
  logic [N:0]    shifted;
  logic [N:0]    trial;

  // Operand magnitudes; |MIN| still fits in N unsigned bits
  assign dvd_neg = i_signed & i_dividend[N-1];
  assign dsr_neg = i_signed & i_divisor[N-1];
  assign dvd_mag = dvd_neg ? (~i_dividend + N'(1)) : i_dividend;
  assign dsr_mag = dsr_neg ? (~i_divisor + N'(1)) : i_divisor;

  // Restoring step: shift in next dividend bit, trial-subtract in N+1 bits
  assign shifted = {rem_q, quo_q[N-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    dvd_d       = dvd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    undef_d     = undef_q;
    ovf_d       = ovf_q;
    busy_d      = o_busy;
    finished_d  = 1'b0;
    quotient_d  = o_quotient;
    remainder_d = o_remainder;
    undefined_d = o_undefined;
    overflow_d  = o_overflow;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          busy_d    = 1'b1;
          dvd_d     = i_dividend;
          dsr_d     = dsr_mag;
          rem_d     = '0;
          quo_d     = dvd_mag;
          neg_quo_d = dvd_neg ^ dsr_neg;
          neg_rem_d = dvd_neg;
          undef_d   = 1'b0;
          ovf_d     = 1'b0;
          if (i_divisor == '0) begin
            undef_d = 1'b1;
            state_d = FIXUP;
          end else if (i_signed && (i_dividend == MIN_VAL) && (i_divisor == '1)) begin
            ovf_d   = 1'b1;
            state_d = FIXUP;
          end else begin
            cnt_d   = CW'(N);
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (!trial[N]) begin
          rem_d = trial[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        finished_d  = 1'b1;
        undefined_d = undef_q;
        overflow_d  = ovf_q;
        if (undef_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else if (ovf_q) begin
          quotient_d  = MIN_VAL;
          remainder_d = '0;
        end else begin
          quotient_d  = neg_quo_q ? (~quo_q + N'(1)) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + N'(1)) : rem_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      undef_q     <= 1'b0;
      ovf_q       <= 1'b0;
      o_busy      <= 1'b0;
      o_finished  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_undefined <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      dvd_q       <= dvd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      undef_q     <= undef_d;
      ovf_q       <= ovf_d;
      o_busy      <= busy_d;
      o_finished  <= finished_d;
      o_quotient  <= quotient_d;
      o_remainder <= remainder_d;
      o_undefined <= undefined_d;
      o_overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_divider_signed.sv
// Self-checking bench for divider_signed (N=4): directed cases, handshake,
// asynchronous reset, exhaustive sweep and a randomized sweep with bus noise.
module tb_divider_signed;

  localparam int unsigned N = 4;
  localparam int MIN_INT = -(2 ** (N - 1));

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic         i_signed;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_busy;
  logic         o_finished;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_undefined;
  logic         o_overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  divider_signed #(.N(N)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_finished  (o_finished),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_undefined (o_undefined),
    .o_overflow  (o_overflow)
  );

  always #5 i_clock = ~i_clock;

  // Edge counter used to measure latency
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Truncating division from plain integer arithmetic plus the special-case rules
  function automatic void ref_div(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic u, output logic o, output int lat);
    int sa, sb;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    u = 1'b0;
    o = 1'b0;
    lat = N + 1;
    if (sb == 0) begin
      q = '1; r = a; u = 1'b1; lat = 1;
    end else if (sgn && sa == MIN_INT && sb == -1) begin
      q = N'(-MIN_INT); r = '0; o = 1'b1; lat = 1;
    end else begin
      q = N'(sa / sb);
      r = N'(sa % sb);
    end
  endfunction

  // Called at a negedge; start edge is the next posedge
  task automatic start_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    i_start = 1'b1; i_signed = sgn; i_dividend = a; i_divisor = b;
    @(posedge i_clock);
    @(negedge i_clock);
    i_start = 1'b0;
    t0 = cyc;
  endtask

  // Waits (bounded) for o_finished; optionally drives noise while the op runs
  task automatic wait_done(input string tag, input bit noise, output int lat, output int busy_n);
    int n;
    n = 0;
    busy_n = 0;
    while (!o_finished && n < 40) begin
      if (o_busy) busy_n++;
      if (noise) begin
        i_start = 1'($urandom_range(0, 1));
        i_signed = 1'($urandom_range(0, 1));
        i_dividend = N'($urandom);
        i_divisor = N'($urandom);
      end
      @(negedge i_clock);
      n++;
    end
    i_start = 1'b0;
    check({tag, " finished"}, 32'(o_finished), 32'd1);
    lat = cyc - t0;
  endtask

  task automatic run_check(input string tag, input logic sgn, input logic [N-1:0] a,
                           input logic [N-1:0] b, input bit noise);
    logic [N-1:0] eq, er;
    logic eu, eo;
    int elat, lat, busy_n;
    ref_div(sgn, a, b, eq, er, eu, eo, elat);
    start_op(sgn, a, b);
    wait_done(tag, noise, lat, busy_n);
    check({tag, " result"}, {o_undefined, o_overflow, o_quotient, o_remainder}, {eu, eo, eq, er});
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(elat));
    check({tag, " busy_at_fin"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int lat, busy_n;
    bit saw_fin;
    i_reset = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_dividend = '0; i_divisor = '0;
    #2 i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
    check("reset_state", {o_busy, o_finished, o_quotient, o_remainder, o_undefined, o_overflow}, 32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("idle_after_reset", {o_busy, o_finished}, 32'd0);

    // Directed cases
    run_check("u 13/3", 1'b0, 4'd13, 4'd3, 1'b0);
    run_check("s -7/2", 1'b1, 4'b1001, 4'b0010, 1'b0);
    run_check("s 7/-2", 1'b1, 4'b0111, 4'b1110, 1'b0);
    run_check("u 9/2", 1'b0, 4'b1001, 4'b0010, 1'b0);
    run_check("u 7/14", 1'b0, 4'b0111, 4'b1110, 1'b0);
    run_check("u 9/0", 1'b0, 4'b1001, 4'b0000, 1'b0);
    run_check("s -8/-1", 1'b1, 4'b1000, 4'b1111, 1'b0);
    run_check("u 8/15", 1'b0, 4'b1000, 4'b1111, 1'b0);
    check("u 13/3 value", 32'(4'd13 / 4'd3), 32'd4);

    // Start pulse while busy is ignored; operand changes have no effect
    start_op(1'b0, 4'd13, 4'd3);
    @(negedge i_clock);
    i_start = 1'b1; i_dividend = 4'd6; i_divisor = 4'd2;
    @(negedge i_clock);
    i_start = 1'b0;
    wait_done("ignore", 1'b0, lat, busy_n);
    check("ignore result", {o_quotient, o_remainder}, {4'd4, 4'd1});
    check("ignore latency", 32'(lat), 32'(N + 1));

    // Start held during the finished cycle is accepted back-to-back
    check("b2b in_fin", 32'(o_finished), 32'd1);
    start_op(1'b0, 4'd6, 4'd2);
    wait_done("b2b", 1'b0, lat, busy_n);
    check("b2b result", {o_quotient, o_remainder}, {4'd3, 4'd0});
    check("b2b latency", 32'(lat), 32'(N + 1));

    // Asynchronous reset mid-operation
    start_op(1'b0, 4'd13, 4'd3);
    @(negedge i_clock);
    check("rst busy_before", 32'(o_busy), 32'd1);
    #2 i_reset = 1'b0;
    #1 check("rst immediate", {o_busy, o_finished, o_quotient, o_remainder, o_undefined, o_overflow}, 32'd0);
    saw_fin = 1'b0;
    repeat (3) begin
      @(negedge i_clock);
      if (o_finished || o_busy) saw_fin = 1'b1;
    end
    i_reset = 1'b1;
    repeat (8) begin
      @(negedge i_clock);
      if (o_finished || o_busy) saw_fin = 1'b1;
    end
    check("rst no_activity", 32'(saw_fin), 32'd0);
    run_check("post_rst 10/4", 1'b0, 4'd10, 4'd4, 1'b0);

    // Exhaustive sweep, random idle gaps between operations
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < (1 << N); a++) begin
        for (int b = 0; b < (1 << N); b++) begin
          run_check($sformatf("sweep s%0d %0d/%0d", s, a, b), 1'(s), N'(a), N'(b), 1'b0);
          if ($urandom_range(0, 3) == 0) @(negedge i_clock);
        end
      end
    end

    // Random operations with noise on the inputs while busy
    for (int k = 0; k < 200; k++) begin
      logic sgn;
      logic [N-1:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a = N'($urandom);
      b = N'($urandom);
      run_check($sformatf("rand s%0d %0d/%0d", sgn, a, b), sgn, a, b, 1'b1);
      if ($urandom_range(0, 2) == 0) @(negedge i_clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
